// File: rtl/mem_pattern_tester_pkg.sv
// Shared types and helpers for the memory pattern tester: FSM states,
// default seed and the expected-data generator.
package mem_test_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WR_WAIT,
        S_RD,
        S_RD_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [7:0] DEFAULT_SEED = 8'hA5;

    // Phase 1 inverts the phase 0 pattern so every bit is exercised both ways.
    function automatic logic [7:0] f_pattern(input logic i_phase,
                                             input logic [3:0] i_addr,
                                             input logic [7:0] i_seed);
        logic [7:0] w_base;
        w_base = {4'h0, i_addr} ^ i_seed;
        return i_phase ? ~w_base : w_base;
    endfunction

endpackage

// File: rtl/mem_pattern_tester_if.sv
// Control/status and register-style memory port of the pattern tester.
// master = tester side, slave = bench/memory side.
interface mem_pattern_tester_if;
    logic       start;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_count;
    logic [3:0] fail_addr;
    logic [7:0] fail_rdata;
    logic       mem_write;
    logic       mem_read;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    modport master (
        input  start, mem_rdata,
        output busy, done, pass, err_count, fail_addr, fail_rdata,
               mem_write, mem_read, mem_addr, mem_wdata
    );

    modport slave (
        output start, mem_rdata,
        input  busy, done, pass, err_count, fail_addr, fail_rdata,
               mem_write, mem_read, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_pattern_tester_wait_timer.sv
// Loadable down-counter timing the idle gap after each memory strobe.
// Loaded during the strobe cycle; expire is high on the last wait cycle.
module mem_test_wait_timer #(
    parameter int WAIT_CYCLES = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    output logic o_expire
);
    localparam int CW = $clog2(WAIT_CYCLES + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(WAIT_CYCLES - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= LOAD_VAL;
        end else if (r_count != '0) begin
            r_count <= r_count - CW'(1);
        end
    end

    assign o_expire = (r_count == '0);
endmodule

// File: rtl/mem_pattern_tester.sv
// Two-phase write/readback pattern tester driving the memory_interface
// register port; reports pass, error count and first failing location.
module mem_pattern_tester
    import mem_test_pkg::*;
#(
    parameter int         DEPTH       = 16,
    parameter int         WAIT_CYCLES = 8,
    parameter logic [7:0] SEED        = DEFAULT_SEED
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    mem_pattern_tester_if.master bus
);
    localparam logic [3:0] LAST_ADDR = 4'(DEPTH - 1);

    state_t     r_state;
    state_t     w_next;
    logic       r_phase;
    logic [3:0] r_addr;
    logic [7:0] r_wdata;
    logic [7:0] r_rdata;
    logic [7:0] r_err_count;
    logic [3:0] r_fail_addr;
    logic [7:0] r_fail_rdata;
    logic       r_pass;

    logic       w_expire;
    logic       w_timer_load;
    logic       w_last;
    logic       w_mismatch;
    logic [7:0] w_expected;

    assign w_timer_load = (r_state == S_WR) || (r_state == S_RD);
    assign w_last       = (r_addr == LAST_ADDR);
    assign w_expected   = f_pattern(r_phase, r_addr, SEED);
    assign w_mismatch   = (r_state == S_CHECK) && (r_rdata != w_expected);

    mem_test_wait_timer #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_load   (w_timer_load),
        .o_expire (w_expire)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (bus.start) w_next = S_WR;
            S_WR:      w_next = S_WR_WAIT;
            S_WR_WAIT: if (w_expire) w_next = w_last ? S_RD : S_WR;
            S_RD:      w_next = S_RD_WAIT;
            S_RD_WAIT: if (w_expire) w_next = S_CHECK;
            S_CHECK: begin
                if (!w_last)      w_next = S_RD;
                else if (!r_phase) w_next = S_WR;
                else              w_next = S_DONE;
            end
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_phase      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_err_count  <= '0;
            r_fail_addr  <= '0;
            r_fail_rdata <= '0;
            r_pass       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.start) begin
                    r_phase      <= 1'b0;
                    r_addr       <= '0;
                    r_wdata      <= f_pattern(1'b0, 4'h0, SEED);
                    r_err_count  <= '0;
                    r_fail_addr  <= '0;
                    r_fail_rdata <= '0;
                    r_pass       <= 1'b0;
                end
                S_WR_WAIT: if (w_expire) begin
                    if (w_last) begin
                        r_addr <= '0;
                    end else begin
                        r_addr  <= r_addr + 4'd1;
                        r_wdata <= f_pattern(r_phase, r_addr + 4'd1, SEED);
                    end
                end
                S_RD_WAIT: if (w_expire) r_rdata <= bus.mem_rdata;
                S_CHECK: begin
                    if (w_mismatch) begin
                        if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
                        // Zero count means this is the first error of the run.
                        if (r_err_count == 8'd0) begin
                            r_fail_addr  <= r_addr;
                            r_fail_rdata <= r_rdata;
                        end
                    end
                    if (!w_last) begin
                        r_addr <= r_addr + 4'd1;
                    end else if (!r_phase) begin
                        r_phase <= 1'b1;
                        r_addr  <= '0;
                        r_wdata <= f_pattern(1'b1, 4'h0, SEED);
                    end else begin
                        r_pass <= (r_err_count == 8'd0) && !w_mismatch;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_write  = (r_state == S_WR);
    assign bus.mem_read   = (r_state == S_RD);
    assign bus.mem_addr   = r_addr;
    assign bus.mem_wdata  = r_wdata;
    assign bus.busy       = (r_state != S_IDLE) && (r_state != S_DONE);
    assign bus.done       = (r_state == S_DONE);
    assign bus.pass       = r_pass;
    assign bus.err_count  = r_err_count;
    assign bus.fail_addr  = r_fail_addr;
    assign bus.fail_rdata = r_fail_rdata;
endmodule

// File: tb/tb_mem_pattern_tester.sv
// Directed bench for mem_pattern_tester: default instance with fault-injecting
// memory model, plus a DEPTH=4 / WAIT_CYCLES=1 instance for spacing checks.
module tb_mem_pattern_tester;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;
    int   rd_mode;

    mem_pattern_tester_if bus_a ();
    mem_pattern_tester_if bus_b ();

    mem_pattern_tester u_dut_a (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_a.master)
    );

    mem_pattern_tester #(.DEPTH(4), .WAIT_CYCLES(1)) u_dut_b (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_b.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem_a [16];
    logic [7:0] mem_b [16];
    logic [7:0] rd_a;
    logic [7:0] rd_b;

    always @(posedge clk) begin
        if (bus_a.mem_write) mem_a[bus_a.mem_addr] <= bus_a.mem_wdata;
        if (bus_a.mem_read)  rd_a <= mem_a[bus_a.mem_addr];
        if (bus_b.mem_write) mem_b[bus_b.mem_addr] <= bus_b.mem_wdata;
        if (bus_b.mem_read)  rd_b <= mem_b[bus_b.mem_addr];
    end

    // rd_mode 1: data bit 3 stuck at 0; rd_mode 2: reads return all zeros
    assign bus_a.mem_rdata = (rd_mode == 1) ? (rd_a & 8'hF7) :
                             (rd_mode == 2) ? 8'h00 : rd_a;
    assign bus_b.mem_rdata = rd_b;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_a(input int repulse_at, input bit check_first,
                         output int lat, output int n_done);
        lat    = 0;
        n_done = 0;
        @(negedge clk);
        bus_a.start = 1'b1;
        while (lat < 2000) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) begin
                bus_a.start = 1'b0;
                if (check_first) begin
                    check_val("first_write", 32'(bus_a.mem_write), 32'd1);
                    check_val("first_read", 32'(bus_a.mem_read), 32'd0);
                    check_val("first_addr", 32'(bus_a.mem_addr), 32'd0);
                    check_val("first_wdata", 32'(bus_a.mem_wdata), 32'hA5);
                    check_val("busy_running", 32'(bus_a.busy), 32'd1);
                end
            end
            if (repulse_at > 0 && lat == repulse_at)     bus_a.start = 1'b1;
            if (repulse_at > 0 && lat == repulse_at + 1) bus_a.start = 1'b0;
            if (bus_a.done) begin
                n_done++;
                break;
            end
        end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (bus_a.done) n_done++;
        end
    endtask

    task automatic check_a_zero(input string tag);
        logic [31:0] w_all;
        w_all = {bus_a.busy, bus_a.done, bus_a.pass, bus_a.mem_write, bus_a.mem_read,
                 bus_a.err_count, bus_a.fail_addr, bus_a.fail_rdata, bus_a.mem_addr};
        check_val(tag, w_all, 32'd0);
        check_val({tag, "_wdata"}, 32'(bus_a.mem_wdata), 32'd0);
    endtask

    int         lat;
    int         n_done;
    int         last_strobe;
    int         min_gap;
    int         both_seen;
    int         n_wr;
    logic [7:0] wd_seq [8];
    logic [7:0] wd_exp [8];

    initial begin
        n_checks    = 0;
        n_fails     = 0;
        rd_mode     = 0;
        rst         = 1'b1;
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_a_zero("reset_a");
        check_val("reset_b_strobes", {30'd0, bus_b.mem_write, bus_b.mem_read}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_a(0, 1'b1, lat, n_done);
        check_val("clean_latency", 32'(lat), 32'd609);
        check_val("clean_pass", 32'(bus_a.pass), 32'd1);
        check_val("clean_errs", 32'(bus_a.err_count), 32'd0);
        check_val("clean_ndone", 32'(n_done), 32'd1);
        check_val("idle_busy", 32'(bus_a.busy), 32'd0);

        rd_mode = 1;
        run_a(0, 1'b0, lat, n_done);
        check_val("stuck_latency", 32'(lat), 32'd609);
        check_val("stuck_errs", 32'(bus_a.err_count), 32'd16);
        check_val("stuck_fail_addr", 32'(bus_a.fail_addr), 32'd8);
        check_val("stuck_fail_rdata", 32'(bus_a.fail_rdata), 32'hA5);
        check_val("stuck_pass", 32'(bus_a.pass), 32'd0);

        rd_mode = 2;
        run_a(0, 1'b0, lat, n_done);
        check_val("zero_errs", 32'(bus_a.err_count), 32'd32);
        check_val("zero_fail_addr", 32'(bus_a.fail_addr), 32'd0);
        check_val("zero_fail_rdata", 32'(bus_a.fail_rdata), 32'h00);
        check_val("zero_pass", 32'(bus_a.pass), 32'd0);

        rd_mode = 0;
        run_a(100, 1'b0, lat, n_done);
        check_val("repulse_latency", 32'(lat), 32'd609);
        check_val("repulse_ndone", 32'(n_done), 32'd1);
        check_val("repulse_pass", 32'(bus_a.pass), 32'd1);

        @(negedge clk);
        bus_a.start = 1'b1;
        for (int c = 1; c <= 300; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) bus_a.start = 1'b0;
        end
        check_val("pre_reset_busy", 32'(bus_a.busy), 32'd1);
        rst = 1'b1;
        #1;
        check_a_zero("midrun_reset");
        repeat (2) @(posedge clk);
        #1;
        check_a_zero("held_reset");
        @(negedge clk);
        rst = 1'b0;
        run_a(0, 1'b0, lat, n_done);
        check_val("post_reset_latency", 32'(lat), 32'd609);
        check_val("post_reset_pass", 32'(bus_a.pass), 32'd1);

        wd_exp = '{8'hA5, 8'hA4, 8'hA7, 8'hA6, 8'h5A, 8'h5B, 8'h58, 8'h59};
        last_strobe = -1;
        min_gap     = 1000;
        both_seen   = 0;
        n_wr        = 0;
        lat         = 0;
        @(negedge clk);
        bus_b.start = 1'b1;
        while (lat < 500) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) bus_b.start = 1'b0;
            if (bus_b.mem_write && bus_b.mem_read) both_seen++;
            if (bus_b.mem_write || bus_b.mem_read) begin
                if (last_strobe >= 0 && (lat - last_strobe - 1) < min_gap)
                    min_gap = lat - last_strobe - 1;
                last_strobe = lat;
            end
            if (bus_b.mem_write && n_wr < 8) begin
                wd_seq[n_wr] = bus_b.mem_wdata;
                n_wr++;
            end
            if (bus_b.done) break;
        end
        check_val("b_latency", 32'(lat), 32'd41);
        check_val("b_min_gap", 32'(min_gap), 32'd1);
        check_val("b_both_strobes", 32'(both_seen), 32'd0);
        check_val("b_num_writes", 32'(n_wr), 32'd8);
        for (int i = 0; i < 8; i++)
            check_val($sformatf("b_wdata_%0d", i), 32'(wd_seq[i]), 32'(wd_exp[i]));
        check_val("b_pass", 32'(bus_b.pass), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
